// File: rtl/mem_if_pkg.sv
// Shared types for the cache-side memory port: FSM states and the queued request record.
package mem_if_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] data;
    logic              wen;
  } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request queue of mem_req_t; head is the oldest entry, valid while not empty.
module mem_req_fifo
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  mem_req_t wdata,
  input  logic     pop,
  output mem_req_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  mem_req_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_request_initiator.sv
// Queues upstream line requests and issues them one at a time on the reqValid/respValid port.
// Define MEM_TIMEOUT_EN to abort requests that stay unanswered for TIMEOUT cycles.
module mem_request_initiator
  import mem_if_pkg::*;
#(
  // Widths must match ADDR_W/LINE_W in mem_if_pkg, which size the queue entries.
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LINE_SIZE     = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [ADDRESS_WIDTH-1:0] inAddress,
  input  logic [LINE_SIZE-1:0]     inData,
  input  logic                     inWen,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [LINE_SIZE-1:0]     outData,
  output logic                     outWen,
  output logic                     outError,
  output logic                     reqValid,
  output logic [ADDRESS_WIDTH-1:0] reqAddress,
  output logic [LINE_SIZE-1:0]     reqDataIn,
  output logic                     reqWen,
  input  logic                     respValid,
  input  logic [LINE_SIZE-1:0]     respDataOut
);

  state_t   state, state_next;
  mem_req_t in_req, head;
  logic     full, empty;
  logic     pop, load, done, abort;

  logic [ADDRESS_WIDTH-1:0] req_address;
  logic [LINE_SIZE-1:0]     req_data;
  logic                     req_wen;
  logic [LINE_SIZE-1:0]     out_data;
  logic                     out_wen;

  assign in_req = '{address: inAddress, data: inData, wen: inWen};

  mem_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inValid),
    .wdata (in_req),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          out_error;

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || load)                      tmo_cnt <= '0;
    else if (state == REQ && !respValid)  tmo_cnt <= tmo_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)        out_error <= 1'b0;
    else if (abort) out_error <= 1'b1;
    else if (done)  out_error <= 1'b0;
  end

  assign outError = out_error;
`else
  logic tmo_hit;
  assign tmo_hit  = 1'b0;
  assign outError = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_next = REQ;
          load       = 1'b1;
        end
      end
      REQ: begin
        // A response arriving on the timeout cycle still completes normally.
        if (respValid) begin
          done       = 1'b1;
          pop        = 1'b1;
          state_next = RESP;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          pop        = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (outReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_address <= '0;
      req_data    <= '0;
      req_wen     <= 1'b0;
      out_data    <= '0;
      out_wen     <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        req_address <= head.address;
        req_data    <= head.data;
        req_wen     <= head.wen;
      end
      if (done) begin
        out_data <= req_wen ? '0 : respDataOut;
        out_wen  <= req_wen;
      end else if (abort) begin
        out_data <= '0;
        out_wen  <= req_wen;
      end
    end
  end

  assign inReady    = ~full;
  assign reqValid   = (state == REQ);
  assign outValid   = (state == RESP);
  assign reqAddress = req_address;
  assign reqDataIn  = req_data;
  assign reqWen     = req_wen;
  assign outData    = out_data;
  assign outWen     = out_wen;

endmodule

// File: tb/tb_mem_request_initiator.sv
// Randomized bench for mem_request_initiator with a memory responder and an in-order scoreboard.
module tb_mem_request_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid, inReady, inWen;
  logic [31:0] inAddress, inData;
  logic        outValid, outReady, outWen, outError;
  logic [31:0] outData;
  logic        reqValid, reqWen;
  logic [31:0] reqAddress, reqDataIn;
  logic        respValid;
  logic [31:0] respDataOut;

  always #5 clk = ~clk;

  mem_request_initiator dut (
    .clk         (clk),
    .rst         (rst),
    .inValid     (inValid),
    .inReady     (inReady),
    .inAddress   (inAddress),
    .inData      (inData),
    .inWen       (inWen),
    .outValid    (outValid),
    .outReady    (outReady),
    .outData     (outData),
    .outWen      (outWen),
    .outError    (outError),
    .reqValid    (reqValid),
    .reqAddress  (reqAddress),
    .reqDataIn   (reqDataIn),
    .reqWen      (reqWen),
    .respValid   (respValid),
    .respDataOut (respDataOut)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        err;
  } exp_t;

  exp_t        req_q[$];
  exp_t        exp_q[$];
  logic [31:0] ref_mem [int];

  // Memory responder: strobes respValid after `delay` request cycles, single-cycle strobe.
  bit          mute = 1'b0;
  bit          rand_delay = 1'b0;
  int          resp_delay = 3;
  logic        rv_s, rw_s;
  logic [31:0] ra_s, rd_s;

  always @(negedge clk) begin
    rv_s = reqValid;
    rw_s = reqWen;
    ra_s = reqAddress;
    rd_s = reqDataIn;
  end

  initial begin
    logic [31:0] mem [int];
    int cnt, cur_delay, idx;
    mem[4]      = 32'hDEADBEEF;
    cnt         = 0;
    cur_delay   = 3;
    respValid   = 1'b0;
    respDataOut = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        respValid <= 1'b0;
        cnt = 0;
      end else if (respValid) begin
        respValid <= 1'b0;
        cnt = 0;
      end else if (rv_s && !mute) begin
        cnt++;
        if (cnt == 1) cur_delay = rand_delay ? int'($urandom_range(1, 6)) : resp_delay;
        if (cnt >= cur_delay) begin
          idx = int'(ra_s[11:2]);
          respValid <= 1'b1;
          if (rw_s) begin
            mem[idx] = rd_s;
            respDataOut <= $urandom;
          end else begin
            respDataOut <= mem.exists(idx) ? mem[idx] : 32'h0;
          end
        end
      end
    end
  end

  bit rand_ordy = 1'b0;
  bit ordy_fix  = 1'b1;

  initial begin
    outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      outReady = rand_ordy ? ($urandom_range(0, 3) != 0) : ordy_fix;
    end
  end

  // Protocol monitor and completion scoreboard.
  logic        prev_rv = 1'b0, prev_ov = 1'b0, prev_resp = 1'b0, prev_ordy = 1'b0;
  logic        first_req = 1'b1;
  logic [64:0] prev_req;
  logic [33:0] prev_out;
  int          run = 0, lo = 0, last_run = 0, unstable = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      first_req = 1'b1;
      run       = 0;
      lo        = 0;
      prev_rv   = 1'b0;
      prev_ov   = 1'b0;
      prev_resp = 1'b0;
    end else begin
      if (reqValid) begin
        if (!prev_rv) begin
          if (!first_req) check("req_gap", 64'(lo >= 2), 64'd1);
          first_req = 1'b0;
          if (req_q.size() == 0) begin
            check("req_unexpected", 64'(reqValid), 64'd0);
          end else begin
            e = req_q.pop_front();
            check("req_addr", 64'(reqAddress), 64'(e.addr));
            check("req_wen", 64'(reqWen), 64'(e.wen));
            if (e.wen) check("req_data", 64'(reqDataIn), 64'(e.data));
          end
          run = 0;
        end else if ({reqAddress, reqDataIn, reqWen} !== prev_req) begin
          unstable++;
        end
        run++;
        lo = 0;
      end else begin
        if (prev_rv) last_run = run;
        lo++;
      end
      if (outValid) begin
        if (!prev_ov && !outError) check("resp_to_out", 64'(prev_resp), 64'd1);
        if (prev_ov && !prev_ordy && {outData, outWen, outError} !== prev_out) unstable++;
        if (outReady) begin
          if (exp_q.size() == 0) begin
            check("out_unexpected", 64'(outValid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(outData), 64'(e.data));
            check("out_wen", 64'(outWen), 64'(e.wen));
            check("out_error", 64'(outError), 64'(e.err));
          end
        end
      end
      prev_rv   = reqValid;
      prev_ov   = outValid;
      prev_resp = respValid;
      prev_ordy = outReady;
      prev_req  = {reqAddress, reqDataIn, reqWen};
      prev_out  = {outData, outWen, outError};
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic w,
                          input logic err);
    exp_t e;
    int   n   = 0;
    int   idx = int'(a[11:2]);
    inAddress = a;
    inData    = d;
    inWen     = w;
    inValid   = 1'b1;
    while (!inReady && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("push_timeout", 64'(inReady), 64'd1);
    e.addr = a;
    e.data = d;
    e.wen  = w;
    e.err  = err;
    req_q.push_back(e);
    e.data = (w || err) ? 32'h0 : (ref_mem.exists(idx) ? ref_mem[idx] : 32'h0);
    if (w && !err) ref_mem[idx] = d;
    exp_q.push_back(e);
    step();
    inValid = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while ((exp_q.size() != 0 || outValid) && n < lim) begin
      step();
      n++;
    end
    if (n >= lim) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    exp_q.delete();
    req_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    inValid   = 1'b0;
    inAddress = '0;
    inData    = '0;
    inWen     = 1'b0;
    ref_mem[4] = 32'hDEADBEEF;
    rst = 1'b1;
    repeat (2) step();
    check("rst_inready", 64'(inReady), 64'd1);
    check("rst_outvalid", 64'(outValid), 64'd0);
    check("rst_reqvalid", 64'(reqValid), 64'd0);
    check("rst_out_fields", {31'h0, outData, outWen, outError}, 64'd0);
    check("rst_req_fields", {reqAddress, reqDataIn}, 64'd0);
    check("rst_reqwen", 64'(reqWen), 64'd0);
    rst = 1'b0;
    step();

    // Single read with a 20-cycle memory latency.
    resp_delay = 20;
    push_req(32'h10, $urandom, 1'b0, 1'b0);
    wait_drain(200);
    check("read_req_len", 64'(last_run), 64'd21);

    // Write then read back the same word.
    resp_delay = 3;
    push_req(32'h20, 32'h12345678, 1'b1, 1'b0);
    push_req(32'h20, $urandom, 1'b0, 1'b0);
    wait_drain(200);

    // Fill the queue, then the fifth push waits for the first pop.
    resp_delay = 5;
    for (int i = 0; i < 4; i++) push_req(32'h40 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    check("full_inready", 64'(inReady), 64'd0);
    inValid = 1'b1;
    n = 0;
    while (!inReady && n < 100) begin
      step();
      n++;
    end
    check("pop_frees_push", 64'(outValid), 64'd1);
    push_req(32'h50, $urandom, 1'b0, 1'b0);
    wait_drain(300);

    // Completion held while upstream stalls; queue still accepts.
    ordy_fix = 1'b0;
    step();
    push_req(32'h10, $urandom, 1'b0, 1'b0);
    n = 0;
    while (!outValid && n < 100) begin
      step();
      n++;
    end
    check("hold_inready", 64'(inReady), 64'd1);
    push_req(32'h60, 32'hA5A5A5A5, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_valid", 64'(outValid), 64'd1);
      check("hold_data", 64'(outData), 64'hDEADBEEF);
      check("hold_reqvalid", 64'(reqValid), 64'd0);
    end
    ordy_fix = 1'b1;
    wait_drain(200);

    // Randomized traffic with random latency and upstream backpressure.
    rand_ordy  = 1'b1;
    rand_delay = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_req(32'($urandom_range(0, 15)) << 2, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end
    wait_drain(2000);
    rand_ordy  = 1'b0;
    rand_delay = 1'b0;
    step();

    // Memory never answers.
    mute = 1'b1;
`ifdef MEM_TIMEOUT_EN
    push_req(32'h44, $urandom, 1'b0, 1'b1);
    wait_drain(300);
    check("tmo_req_len", 64'(last_run), 64'd64);
`else
    push_req(32'h44, $urandom, 1'b0, 1'b0);
    repeat (100) step();
    check("no_tmo_reqvalid", 64'(reqValid), 64'd1);
    do_reset();
`endif
    mute = 1'b0;
    step();

    // Reset in the fifth request cycle with three requests queued.
    mute = 1'b1;
    for (int i = 0; i < 3; i++) push_req(32'h80 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    n = 0;
    while (run < 5 && n < 50) begin
      step();
      n++;
    end
    check("rst_wait_req5", 64'(run), 64'd5);
    rst = 1'b1;
    step();
    check("midrst_reqvalid", 64'(reqValid), 64'd0);
    check("midrst_outvalid", 64'(outValid), 64'd0);
    check("midrst_inready", 64'(inReady), 64'd1);
    check("midrst_reqaddr", 64'(reqAddress), 64'd0);
    exp_q.delete();
    req_q.delete();
    rst  = 1'b0;
    mute = 1'b0;
    repeat (10) step();
    check("midrst_flushed", 64'(reqValid), 64'd0);

    check("held_stable", 64'(unstable), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
